ccff_bitstream_loader: RTL

- Host-side programmer for the configuration flip-flop chain threaded through connection and switch blocks (ccff_head → … → ccff_tail).
- Accepts bitstream words over a valid/ready stream, serialises them LSB-first onto the chain head, and gates chain shifting through a per-bit clock enable.
- Captures the bits leaving the chain tail and returns them as readback words, so prior contents can be verified.
- One instance per chain; sits between the configuration host interface and the fabric chain.

---
 rtl/ccff_pkg.sv | 21 ++
 rtl/ccff_rb_packer.sv | 63 ++++++
 rtl/ccff_bitstream_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ccff_pkg.sv
// ccff_pkg: shared types and helpers for the configuration-chain loader.
//   ccff_state_e     loader FSM states (IDLE, FETCH, SHIFT, FLUSH)
//   CBY_CHAIN_LEN    default chain length of a connection block (Y)
//   words_for_chain  number of WORD_W-bit words needed to cover a chain
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    FLUSH = 2'd3
  } ccff_state_e;

  localparam int CBY_CHAIN_LEN = 58;

  // ceil(len / w)
  function automatic int words_for_chain(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// ccff_rb_packer: packs bits leaving the chain tail into readback words and
// holds each finished word under a valid/ready handshake.
//   prog_clk, pReset  clock, asynchronous active-low reset
//   clear             drop any partial or pending word (abort)
//   sample_en         a chain shift happens this cycle; capture sample_bit
//   sample_bit        ccff_tail value before the shift edge
//   sample_idx        bit position of sample_bit within the current word
//   word_end          this sample completes a word (full or final partial)
//   rb_ready          consumer ready
//   rb_valid, rb_word readback word and its valid
//   stall             a finished word is waiting and the consumer is not ready
module ccff_rb_packer
  import ccff_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              clear,
  input  logic              sample_en,
  input  logic              sample_bit,
  input  logic [IDX_W-1:0]  sample_idx,
  input  logic              word_end,
  input  logic              rb_ready,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_word,
  output logic              stall
);

  logic [WORD_W-1:0] rb_shreg;
  logic [WORD_W-1:0] rb_next;

  // rb_shreg is cleared after every emitted word, so a final partial word
  // arrives zero-padded in its upper bits.
  assign rb_next = rb_shreg | (WORD_W'(sample_bit) << sample_idx);
  assign stall   = rb_valid & ~rb_ready;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      rb_valid <= 1'b0;
      rb_word  <= '0;
      rb_shreg <= '0;
    end else if (clear) begin
      rb_valid <= 1'b0;
      rb_shreg <= '0;
    end else begin
      if (rb_valid && rb_ready) rb_valid <= 1'b0;
      // sample_en is never high while stalled, so rb_word cannot change
      // under a pending word; an emit in the handshake cycle re-arms valid.
      if (sample_en) begin
        if (word_end) begin
          rb_word  <= rb_next;
          rb_valid <= 1'b1;
          rb_shreg <= '0;
        end else begin
          rb_shreg <= rb_next;
        end
      end
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises bitstream words LSB-first onto a
// configuration flip-flop chain and returns the displaced contents as
// readback words.
//   prog_clk, pReset         clock, asynchronous active-low reset
//   cfg_start / cfg_abort    begin a load (IDLE only) / return to IDLE
//   cfg_word_valid/_ready    input word stream, cfg_word bit 0 shifted first
//   ccff_head, ccff_shift_en serial data and clock enable to the chain
//   ccff_tail                serial data from the chain tail
//   rb_valid/rb_ready/rb_word readback word stream
//   busy, done               not idle / one-cycle load-complete pulse
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CBY_CHAIN_LEN,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_word_valid,
  input  logic [WORD_W-1:0] cfg_word,
  output logic              cfg_word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_word,
  input  logic              rb_ready,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(WORD_W + 1);

  ccff_state_e       state, state_nx;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  bit_cnt;
  logic              stall;
  logic              last_bit;
  logic              word_last;
  logic              load_word;
  logic              start_load;

  assign last_bit  = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign word_last = (bit_idx == IDX_W'(WORD_W - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx       = state;
    cfg_word_ready = 1'b0;
    ccff_head      = 1'b0;
    ccff_shift_en  = 1'b0;
    done           = 1'b0;
    load_word      = 1'b0;
    start_load     = 1'b0;
    // Abort wins over everything: no accept, no shift, no done this cycle.
    if (cfg_abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            start_load = 1'b1;
            state_nx   = FETCH;
          end
        end
        FETCH: begin
          cfg_word_ready = 1'b1;
          if (cfg_word_valid) begin
            load_word = 1'b1;
            state_nx  = SHIFT;
          end
        end
        SHIFT: begin
          ccff_head = shreg[0];
          if (!stall) begin
            ccff_shift_en = 1'b1;
            if (last_bit)       state_nx = FLUSH;
            else if (word_last) state_nx = FETCH;
          end
        end
        FLUSH: begin
          if (!rb_valid) begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state   <= IDLE;
      bit_idx <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nx;
      if (start_load) bit_cnt <= '0;
      if (load_word)  bit_idx <= '0;
      if (ccff_shift_en) begin
        bit_idx <= bit_idx + IDX_W'(1);
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // Input word shift register: data path only, no reset needed.
  always_ff @(posedge prog_clk) begin
    if (load_word)          shreg <= cfg_word;
    else if (ccff_shift_en) shreg <= shreg >> 1;
  end

  ccff_rb_packer #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_rb_packer (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .clear      (cfg_abort),
    .sample_en  (ccff_shift_en),
    .sample_bit (ccff_tail),
    .sample_idx (bit_idx),
    .word_end   (word_last || last_bit),
    .rb_ready   (rb_ready),
    .rb_valid   (rb_valid),
    .rb_word    (rb_word),
    .stall      (stall)
  );

endmodule
